// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM (Moore; pc_en in BRANCH follows the zero flag).
// Optional feature macro: MC_CONTROL_JUMP_EN adds the JUMP state for op 000010.
module mc_control #(
    parameter int unsigned ILLEGAL_HALT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] aluop,
    output logic [1:0] alusrca,
    output logic [2:0] alusrcb,
    output logic       pc_en,
    output logic [1:0] pcsource,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] dbg_state_o
);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_R_EXE   = 4'd7,
        S_R_WB    = 4'd8,
        S_BRANCH  = 4'd9,
        S_I_EXE   = 4'd10,
        S_I_WB    = 4'd11,
`ifdef MC_CONTROL_JUMP_EN
        S_JUMP    = 4'd12,
`endif
        S_HALT    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
`ifdef MC_CONTROL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd12;

    // Where DECODE goes on an unsupported instruction.
    localparam state_t S_ILLEGAL_NEXT = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;

    state_t state_q, state_d;
    logic   funct_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state_o = state_q;

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: funct_ok = 1'b1;
            default:                            funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        aluop      = 4'd0;
        alusrca    = 2'd0;
        alusrcb    = 3'd0;
        pc_en      = 1'b0;
        pcsource   = 2'd0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                memread = 1'b1;
                irwrite = 1'b1;
                alusrcb = 3'd1;
                aluop   = ALU_ADD;
                pc_en   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is examined.
                alusrcb = 3'd3;
                aluop   = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEM_ADR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_ORI, OP_LUI: state_d = S_I_EXE;
`ifdef MC_CONTROL_JUMP_EN
                    OP_J:           state_d = S_JUMP;
`endif
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_R_EXE;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_ILLEGAL_NEXT;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = S_ILLEGAL_NEXT;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alusrca = 2'd1;
                alusrcb = 3'd2;
                aluop   = ALU_ADD;
                state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_R_EXE: begin
                alusrca = 2'd1;
                case (funct)
                    F_ADDU:  aluop = ALU_ADD;
                    F_SUBU:  aluop = ALU_SUB;
                    F_AND:   aluop = ALU_AND;
                    F_OR:    aluop = ALU_OR;
                    F_SLT:   aluop = ALU_SLT;
                    default: aluop = 4'd0;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 2'd1;
                aluop      = ALU_SUB;
                pcsource   = 2'd1;
                pc_en      = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EXE: begin
                aluop = ALU_OR;
                if (op == OP_LUI) begin
                    alusrca = 2'd2;
                    alusrcb = 3'd5;
                end else begin
                    alusrca = 2'd1;
                    alusrcb = 3'd4;
                end
                state_d = S_I_WB;
            end
            S_I_WB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_CONTROL_JUMP_EN
            S_JUMP: begin
                pc_en      = 1'b1;
                pcsource   = 2'd2;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control; one instance per ILLEGAL_HALT setting.
module tb_mc_control;

    localparam logic [3:0] ST_RST = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEM_ADR = 4'd3;
    localparam logic [3:0] ST_MEM_RD = 4'd4, ST_MEM_WB = 4'd5, ST_MEM_WR = 4'd6, ST_R_EXE = 4'd7;
    localparam logic [3:0] ST_R_WB = 4'd8, ST_BRANCH = 4'd9, ST_I_EXE = 4'd10, ST_I_WB = 4'd11;
    localparam logic [3:0] ST_JUMP = 4'd12, ST_HALT = 4'd13;

    logic       clk = 1'b0;
    logic       rst_n, rst1_n, zero;
    logic [5:0] op, funct;

    logic [3:0] aluop0, aluop1, dbg0, dbg1;
    logic [1:0] srca0, srca1, pcs0, pcs1;
    logic [2:0] srcb0, srcb1;
    logic       pce0, iord0, mr0, mw0, irw0, rw0, rd0, mtr0, done0, ill0;
    logic       pce1, iord1, mr1, mw1, irw1, rw1, rd1, mtr1, done1, ill1;
    logic [20:0] ctl0, ctl1;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  halt_chk = 1'b0;

    logic [20:0] c_fetch, c_decode, c_ill, c_madr, c_mrd, c_mwb, c_mwr, c_rwb, c_iwb;
    logic [20:0] c_ori, c_lui, c_jump;

    always #5 clk = ~clk;

    mc_control #(.ILLEGAL_HALT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .aluop(aluop0), .alusrca(srca0), .alusrcb(srcb0), .pc_en(pce0), .pcsource(pcs0),
        .iord(iord0), .memread(mr0), .memwrite(mw0), .irwrite(irw0), .regwrite(rw0),
        .regdst(rd0), .memtoreg(mtr0), .instr_done(done0), .illegal(ill0), .dbg_state_o(dbg0)
    );

    mc_control #(.ILLEGAL_HALT(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .op(op), .funct(funct), .zero(zero),
        .aluop(aluop1), .alusrca(srca1), .alusrcb(srcb1), .pc_en(pce1), .pcsource(pcs1),
        .iord(iord1), .memread(mr1), .memwrite(mw1), .irwrite(irw1), .regwrite(rw1),
        .regdst(rd1), .memtoreg(mtr1), .instr_done(done1), .illegal(ill1), .dbg_state_o(dbg1)
    );

    assign ctl0 = {aluop0, srca0, srcb0, pce0, pcs0, iord0, mr0, mw0, irw0, rw0, rd0, mtr0, done0, ill0};
    assign ctl1 = {aluop1, srca1, srcb1, pce1, pcs1, iord1, mr1, mw1, irw1, rw1, rd1, mtr1, done1, ill1};

    // Packs one row of the expected-output table in the same order as ctl0.
    function automatic logic [20:0] mk(int alu, int sa, int sb, int pce, int pcs, int io, int mr,
                                       int mw, int irw, int rw, int rd, int mtr, int dn, int il);
        return {alu[3:0], sa[1:0], sb[2:0], pce[0], pcs[1:0], io[0], mr[0], mw[0], irw[0],
                rw[0], rd[0], mtr[0], dn[0], il[0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic [3:0] es, input logic [20:0] ec);
        @(posedge clk);
        #1;
        check_eq({tag, ".state"}, 32'(dbg0), 32'(es));
        check_eq({tag, ".ctl"}, 32'(ctl0), 32'(ec));
        if (halt_chk) begin
            check_eq({tag, ".h_state"}, 32'(dbg1), 32'(ST_HALT));
            check_eq({tag, ".h_ctl"}, 32'(ctl1), 32'd0);
        end
    endtask

    task automatic do_mem(input logic [5:0] o, input bit is_load);
        op = o;
        step_chk("mem.dec", ST_DECODE, c_decode);
        step_chk("mem.adr", ST_MEM_ADR, c_madr);
        if (is_load) begin
            step_chk("lw.rd", ST_MEM_RD, c_mrd);
            step_chk("lw.wb", ST_MEM_WB, c_mwb);
        end else begin
            step_chk("sw.wr", ST_MEM_WR, c_mwr);
        end
        step_chk("mem.fetch", ST_FETCH, c_fetch);
    endtask

    task automatic do_r(input logic [5:0] f, input int alu);
        op = 6'b000000;
        funct = f;
        step_chk($sformatf("r%0h.dec", f), ST_DECODE, c_decode);
        step_chk($sformatf("r%0h.exe", f), ST_R_EXE, mk(alu, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step_chk($sformatf("r%0h.wb", f), ST_R_WB, c_rwb);
        step_chk($sformatf("r%0h.fetch", f), ST_FETCH, c_fetch);
    endtask

    task automatic do_i(input string tag, input logic [5:0] o, input logic [20:0] exe);
        op = o;
        step_chk({tag, ".dec"}, ST_DECODE, c_decode);
        step_chk({tag, ".exe"}, ST_I_EXE, exe);
        step_chk({tag, ".wb"}, ST_I_WB, c_iwb);
        step_chk({tag, ".fetch"}, ST_FETCH, c_fetch);
    endtask

    task automatic do_beq(input logic z);
        op = 6'b000100;
        zero = z;
        step_chk("beq.dec", ST_DECODE, c_decode);
        step_chk($sformatf("beq_z%0d.br", z), ST_BRANCH, mk(3, 1, 0, int'(z), 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step_chk("beq.fetch", ST_FETCH, c_fetch);
        zero = 1'b0;
    endtask

    task automatic do_illegal(input string tag, input logic [5:0] o, input logic [5:0] f);
        op = o;
        funct = f;
        step_chk({tag, ".dec"}, ST_DECODE, c_ill);
        step_chk({tag, ".fetch"}, ST_FETCH, c_fetch);
    endtask

    // Counts cycles from FETCH (cycle 1) to the instr_done pulse, bounded.
    task automatic run_lat(input string tag, input logic [5:0] o, input logic [5:0] f, input int exp);
        int cnt;
        op = o;
        funct = f;
        cnt = 1;
        while (!done0 && cnt < 12) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_eq({tag, ".latency"}, 32'(cnt), 32'(exp));
        step_chk({tag, ".fetch"}, ST_FETCH, c_fetch);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        c_fetch  = mk(2, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        c_decode = mk(2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        c_ill    = mk(2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        c_madr   = mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        c_mrd    = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        c_mwb    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        c_mwr    = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        c_rwb    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        c_iwb    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        c_ori    = mk(5, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        c_lui    = mk(5, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        c_jump   = mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        rst_n  = 1'b0;
        rst1_n = 1'b0;
        op     = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.state", 32'(dbg0), 32'(ST_RST));
        check_eq("rst.ctl", 32'(ctl0), 32'd0);
        check_eq("rst.h_state", 32'(dbg1), 32'(ST_RST));
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        op     = 6'b100011;
        step_chk("fetch0", ST_FETCH, c_fetch);

        do_mem(6'b100011, 1'b1);
        do_mem(6'b101011, 1'b0);

        do_r(6'b101010, 12);
        do_r(6'b100001, 2);
        do_r(6'b100011, 3);
        do_r(6'b100100, 4);
        do_r(6'b100101, 5);

        do_i("lui", 6'b001111, c_lui);
        do_i("ori", 6'b001101, c_ori);

        do_beq(1'b1);
        do_beq(1'b0);

        // First unsupported op: the halting instance must latch into HALT.
        op = 6'b111111;
        step_chk("op3f.dec", ST_DECODE, c_ill);
        check_eq("op3f.h_dec_state", 32'(dbg1), 32'(ST_DECODE));
        check_eq("op3f.h_dec_ctl", 32'(ctl1), 32'(c_ill));
        step_chk("op3f.fetch", ST_FETCH, c_fetch);
        check_eq("op3f.h_halt", 32'(dbg1), 32'(ST_HALT));
        halt_chk = 1'b1;

        do_illegal("funct0", 6'b000000, 6'b000000);

`ifdef MC_CONTROL_JUMP_EN
        op = 6'b000010;
        step_chk("j.dec", ST_DECODE, c_decode);
        step_chk("j.jump", ST_JUMP, c_jump);
        step_chk("j.fetch", ST_FETCH, c_fetch);
`else
        do_illegal("j_off", 6'b000010, 6'b000000);
`endif

        // Reset asserted while the load is reading memory.
        op = 6'b100011;
        step_chk("rlw.dec", ST_DECODE, c_decode);
        step_chk("rlw.adr", ST_MEM_ADR, c_madr);
        step_chk("rlw.rd", ST_MEM_RD, c_mrd);
        rst_n = 1'b0;
        step_chk("rlw.rst", ST_RST, 21'd0);
        rst_n = 1'b1;
        step_chk("rlw.fetch", ST_FETCH, c_fetch);

        run_lat("lat_lw", 6'b100011, 6'b000000, 5);
        run_lat("lat_sw", 6'b101011, 6'b000000, 4);
        run_lat("lat_r", 6'b000000, 6'b100101, 4);
        run_lat("lat_ori", 6'b001101, 6'b000000, 4);
        run_lat("lat_beq", 6'b000100, 6'b000000, 3);

        // Only reset releases the halting instance.
        halt_chk = 1'b0;
        rst1_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("h_rst.state", 32'(dbg1), 32'(ST_RST));
        check_eq("h_rst.ctl", 32'(ctl1), 32'd0);
        rst1_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("h_rst.fetch", 32'(dbg1), 32'(ST_FETCH));
        check_eq("h_rst.fetch_ctl", 32'(ctl1), 32'(c_fetch));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
